// File: rtl/branch_seq_ctrl_pkg.sv
// Shared definitions for the conditional-branch sequencer: state encodings,
// default opcodes, condition codes and the opcode legality helper.
package branch_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_COND  = 3'd1,
        ST_WAIT_CON = 3'd2,
        ST_LINK     = 3'd3,
        ST_RD_TGT   = 3'd4,
        ST_DONE     = 3'd5,
        ST_ERR      = 3'd6
    } state_e;

    localparam logic [4:0] OPC_BR_DEF  = 5'b01000;
    localparam logic [4:0] OPC_BRL_DEF = 5'b01001;
    localparam int         CNT_W_DEF   = 16;

    localparam logic [1:0] COND_ZR = 2'b00;
    localparam logic [1:0] COND_NZ = 2'b01;
    localparam logic [1:0] COND_PL = 2'b10;
    localparam logic [1:0] COND_MI = 2'b11;

    // brl only counts as a branch when the link path is built in
    function automatic logic is_branch_op(input logic [4:0] opc,
                                          input logic [4:0] opc_br,
                                          input logic [4:0] opc_brl,
                                          input logic       link_en);
        return (opc == opc_br) || (link_en && (opc == opc_brl));
    endfunction

endpackage

// File: rtl/branch_stat_cnt.sv
// Wrapping statistics counter with synchronous clear and increment enable.
module branch_stat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_r;

    // Count up on inc; all-ones rolls over to zero
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/branch_seq_ctrl.sv
// Multi-cycle br/brl sequencer with start/done handshake and branch statistics.
// Define BRL_LINK_EN to make brl legal and build the LINK state.
module branch_seq_ctrl
    import branch_seq_ctrl_pkg::*;
#(
    parameter logic [4:0] OPC_BR  = OPC_BR_DEF,
    parameter logic [4:0] OPC_BRL = OPC_BRL_DEF,
    parameter int         CNT_W   = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [31:0]      IR,
    input  logic             con_q,
    output logic             gra,
    output logic             grb,
    output logic             grc,
    output logic             r_out,
    output logic             r_in,
    output logic             con_in,
    output logic             pc_out,
    output logic             pc_in,
    output logic             busy,
    output logic             done,
    output logic             taken,
    output logic             illegal,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] tk_cnt
);

`ifdef BRL_LINK_EN
    localparam logic LINK_EN = 1'b1;
`else
    localparam logic LINK_EN = 1'b0;
`endif

    state_e state_r;
    logic   taken_q_r;
    logic   legal_s;
    logic   unused_ir_s;

    assign legal_s     = is_branch_op(IR[31:27], OPC_BR, OPC_BRL, LINK_EN);
    assign unused_ir_s = ^IR[26:0];

    // Sequencer: strobes are registered alongside the state they belong to
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r   <= ST_IDLE;
            taken_q_r <= 1'b0;
            gra       <= 1'b0;
            grb       <= 1'b0;
            grc       <= 1'b0;
            r_out     <= 1'b0;
            con_in    <= 1'b0;
            pc_in     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            taken     <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            gra     <= 1'b0;
            grb     <= 1'b0;
            grc     <= 1'b0;
            r_out   <= 1'b0;
            con_in  <= 1'b0;
            pc_in   <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
            busy    <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (start && legal_s) begin
                        state_r <= ST_RD_COND;
                        grc     <= 1'b1;
                        r_out   <= 1'b1;
                        con_in  <= 1'b1;
                    end else if (start) begin
                        state_r <= ST_ERR;
                        done    <= 1'b1;
                        illegal <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                ST_RD_COND: begin
                    state_r <= ST_WAIT_CON;
                end
                ST_WAIT_CON: begin
                    taken_q_r <= con_q;
                    if (!con_q) begin
                        // taken is published with done so it is valid in the done cycle
                        state_r <= ST_DONE;
                        done    <= 1'b1;
                        taken   <= 1'b0;
                    end else
`ifdef BRL_LINK_EN
                    if (IR[31:27] == OPC_BRL) begin
                        state_r <= ST_LINK;
                        gra     <= 1'b1;
                    end else
`endif
                    begin
                        state_r <= ST_RD_TGT;
                        grb     <= 1'b1;
                        r_out   <= 1'b1;
                        pc_in   <= 1'b1;
                    end
                end
                ST_LINK: begin
                    state_r <= ST_RD_TGT;
                    grb     <= 1'b1;
                    r_out   <= 1'b1;
                    pc_in   <= 1'b1;
                end
                ST_RD_TGT: begin
                    state_r <= ST_DONE;
                    done    <= 1'b1;
                    taken   <= taken_q_r;
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
                ST_ERR: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRL_LINK_EN
    // LINK drives PC onto BUS and writes it into R[ra]; gra marks exactly that state
    assign pc_out = gra;
    assign r_in   = gra;
`else
    assign pc_out = 1'b0;
    assign r_in   = 1'b0;
`endif

    branch_stat_cnt #(.CNT_W(CNT_W)) u_br_cnt (
        .clk (Clk),
        .clr (Reset),
        .inc (state_r == ST_DONE),
        .cnt (br_cnt)
    );

    branch_stat_cnt #(.CNT_W(CNT_W)) u_tk_cnt (
        .clk (Clk),
        .clr (Reset),
        .inc ((state_r == ST_DONE) && taken_q_r),
        .cnt (tk_cnt)
    );

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Directed self-checking bench for branch_seq_ctrl; follows BRL_LINK_EN as built.
module tb_branch_seq_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [31:0] IR;
    logic        con_q;
    logic        gra, grb, grc, r_out, r_in, con_in, pc_out, pc_in;
    logic        busy, done, taken, illegal;
    logic [15:0] br_cnt, tk_cnt;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_br = 16'd0;
    logic [15:0] exp_tk = 16'd0;
    logic [10:0] obs_s;

    // bit order: gra grb grc r_out r_in con_in pc_out pc_in busy done illegal
    localparam logic [10:0] V_IDLE = 11'b00000000000;
    localparam logic [10:0] V_RDC  = 11'b00110100100;
    localparam logic [10:0] V_WAIT = 11'b00000000100;
    localparam logic [10:0] V_LINK = 11'b10001010100;
    localparam logic [10:0] V_TGT  = 11'b01010001100;
    localparam logic [10:0] V_DONE = 11'b00000000110;
    localparam logic [10:0] V_ERR  = 11'b00000000111;

    localparam logic [31:0] IR_BR_ZR  = 32'h4000_0000;
    localparam logic [31:0] IR_BR_NZ  = 32'h4008_0000;
    localparam logic [31:0] IR_BRL    = 32'h4800_0000;
    localparam logic [31:0] IR_NONBR  = 32'h1800_0000;

    assign obs_s = {gra, grb, grc, r_out, r_in, con_in, pc_out, pc_in, busy, done, illegal};

    branch_seq_ctrl dut (
        .Clk(Clk), .Reset(Reset), .start(start), .IR(IR), .con_q(con_q),
        .gra(gra), .grb(grb), .grc(grc), .r_out(r_out), .r_in(r_in),
        .con_in(con_in), .pc_out(pc_out), .pc_in(pc_in), .busy(busy),
        .done(done), .taken(taken), .illegal(illegal),
        .br_cnt(br_cnt), .tk_cnt(tk_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock, sample just after the edge, single-bus-driver check every cycle
    task automatic step();
        @(posedge Clk);
        #1;
        chk("bus_excl", {15'd0, r_out & pc_out}, 16'd0);
    endtask

    task automatic launch(input logic [31:0] ir, input logic c);
        IR    = ir;
        con_q = c;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0; IR = 32'd0; con_q = 1'b0;
        step(); step();
        chk("rst_out", {5'd0, obs_s}, {5'd0, V_IDLE});
        chk("rst_taken", {15'd0, taken}, 16'd0);
        chk("rst_br", br_cnt, 16'd0);
        chk("rst_tk", tk_cnt, 16'd0);
        Reset = 1'b0;
        step();

        // 1: br taken, done in cycle 4
        launch(IR_BR_ZR, 1'b1);
        chk("t1_c1", {5'd0, obs_s}, {5'd0, V_RDC});
        step(); chk("t1_c2", {5'd0, obs_s}, {5'd0, V_WAIT});
        step(); chk("t1_c3", {5'd0, obs_s}, {5'd0, V_TGT});
        step(); chk("t1_c4", {5'd0, obs_s}, {5'd0, V_DONE});
        chk("t1_taken", {15'd0, taken}, 16'd1);
        exp_br = 16'd1; exp_tk = 16'd1;
        step(); chk("t1_idle", {5'd0, obs_s}, {5'd0, V_IDLE});
        chk("t1_br", br_cnt, exp_br);
        chk("t1_tk", tk_cnt, exp_tk);
        chk("t1_hold", {15'd0, taken}, 16'd1);

        // 2: br not taken, done in cycle 3
        launch(IR_BR_NZ, 1'b0);
        chk("t2_c1", {5'd0, obs_s}, {5'd0, V_RDC});
        step(); chk("t2_c2", {5'd0, obs_s}, {5'd0, V_WAIT});
        step(); chk("t2_c3", {5'd0, obs_s}, {5'd0, V_DONE});
        chk("t2_taken", {15'd0, taken}, 16'd0);
        exp_br = 16'd2;
        step(); chk("t2_idle", {5'd0, obs_s}, {5'd0, V_IDLE});
        chk("t2_br", br_cnt, exp_br);
        chk("t2_tk", tk_cnt, exp_tk);

        // 3: brl taken
        launch(IR_BRL, 1'b1);
`ifdef BRL_LINK_EN
        chk("t3_c1", {5'd0, obs_s}, {5'd0, V_RDC});
        step(); chk("t3_c2", {5'd0, obs_s}, {5'd0, V_WAIT});
        step(); chk("t3_c3", {5'd0, obs_s}, {5'd0, V_LINK});
        step(); chk("t3_c4", {5'd0, obs_s}, {5'd0, V_TGT});
        step(); chk("t3_c5", {5'd0, obs_s}, {5'd0, V_DONE});
        chk("t3_taken", {15'd0, taken}, 16'd1);
        exp_br = 16'd3; exp_tk = 16'd2;
`else
        chk("t3_c1", {5'd0, obs_s}, {5'd0, V_ERR});
        chk("t3_taken", {15'd0, taken}, 16'd0);
`endif
        step(); chk("t3_idle", {5'd0, obs_s}, {5'd0, V_IDLE});
        chk("t3_br", br_cnt, exp_br);
        chk("t3_tk", tk_cnt, exp_tk);

        // 4: non-branch opcode; taken holds its previous value
        launch(IR_NONBR, 1'b1);
        chk("t4_c1", {5'd0, obs_s}, {5'd0, V_ERR});
        step(); chk("t4_idle", {5'd0, obs_s}, {5'd0, V_IDLE});
        chk("t4_br", br_cnt, exp_br);
        chk("t4_tk", tk_cnt, exp_tk);
`ifdef BRL_LINK_EN
        chk("t4_taken", {15'd0, taken}, 16'd1);
`else
        chk("t4_taken", {15'd0, taken}, 16'd0);
`endif

        // 5a: start held high while busy and during done is ignored
        launch(IR_BR_NZ, 1'b0);
        start = 1'b1;
        chk("t5a_c1", {5'd0, obs_s}, {5'd0, V_RDC});
        step(); chk("t5a_c2", {5'd0, obs_s}, {5'd0, V_WAIT});
        step(); chk("t5a_c3", {5'd0, obs_s}, {5'd0, V_DONE});
        start = 1'b0;
        exp_br = exp_br + 16'd1;
        step(); chk("t5a_c4", {5'd0, obs_s}, {5'd0, V_IDLE});
        step(); chk("t5a_c5", {5'd0, obs_s}, {5'd0, V_IDLE});
        chk("t5a_br", br_cnt, exp_br);

        // 5b: reset in RD_TGT aborts without done
        launch(IR_BR_ZR, 1'b1);
        step(); step();
        chk("t5b_tgt", {5'd0, obs_s}, {5'd0, V_TGT});
        Reset = 1'b1;
        step();
        chk("t5b_out", {5'd0, obs_s}, {5'd0, V_IDLE});
        chk("t5b_taken", {15'd0, taken}, 16'd0);
        chk("t5b_br", br_cnt, 16'd0);
        Reset = 1'b0;
        step(); step();
        chk("t5b_nodone", {5'd0, obs_s}, {5'd0, V_IDLE});

        // 6: counters wrap from all-ones
        force dut.u_br_cnt.cnt_r = 16'hFFFF;
        force dut.u_tk_cnt.cnt_r = 16'hFFFF;
        #1;
        release dut.u_br_cnt.cnt_r;
        release dut.u_tk_cnt.cnt_r;
        step();
        chk("t6_pre", br_cnt, 16'hFFFF);
        launch(IR_BR_ZR, 1'b1);
        step(); step();
        step(); chk("t6_done", {5'd0, obs_s}, {5'd0, V_DONE});
        step();
        chk("t6_br", br_cnt, 16'h0000);
        chk("t6_tk", tk_cnt, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
